// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencer and coefficient-port arbiter for the time-multiplexed
// FIR datapath. One sample is accepted, written into the circular delay line,
// and then a single MAC steps across all taps. A flush cycle covers the
// one-stage product pipeline, and a done cycle loads the result register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | wait for a sample; coefficient writes are granted here first
// LOAD  | write the captured sample at wr_ptr; clear tap counter k
// MAC   | NTAPS cycles: coef_addr=k, dl_raddr=wr_ptr-k, accumulate
// FLUSH | drain the product pipeline into the accumulator
// DONE  | load the output register; advance wr_ptr
module fir_seq_ctrl #(
   parameter int NTAPS = 8,
   parameter int TAP_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             smp_valid,
   output logic             smp_ready,
   output logic             in_cap,
   output logic             dl_we,
   output logic [TAP_W-1:0] dl_waddr,
   output logic [TAP_W-1:0] dl_raddr,
   input  logic             coef_wr_req,
   input  logic [TAP_W-1:0] coef_wr_addr,
   output logic             coef_wr_ack,
   output logic [TAP_W-1:0] coef_addr,
   output logic             coef_we,
   output logic             mac_clr,
   output logic             mac_en,
   output logic             y_load,
   output logic             x_trio,
   output logic             y_trio,
   output logic             ovr,
   input  logic             ovr_clr
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MAC   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [TAP_W-1:0] K_LAST = TAP_W'(NTAPS - 1);

   state_t           state, state_nxt;
   logic [TAP_W-1:0] k, k_nxt;
   logic [TAP_W-1:0] wr_ptr, wr_ptr_nxt;
   logic             ovr_nxt;

   // State, counters and registered pins; everything holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         k      <= '0;
         wr_ptr <= '0;
         ovr    <= 1'b0;
         x_trio <= 1'b0;
         y_trio <= 1'b0;
      end else if (ena) begin
         state  <= state_nxt;
         k      <= k_nxt;
         wr_ptr <= wr_ptr_nxt;
         ovr    <= ovr_nxt;
         x_trio <= in_cap;
         y_trio <= y_load;
      end
   end

   // Next-state and strobe decode; ena low suppresses every strobe.
   always_comb begin
      state_nxt   = state;
      k_nxt       = k;
      wr_ptr_nxt  = wr_ptr;
      smp_ready   = 1'b0;
      in_cap      = 1'b0;
      coef_wr_ack = 1'b0;
      dl_we       = 1'b0;
      mac_en      = 1'b0;
      mac_clr     = 1'b0;
      y_load      = 1'b0;

      case (state)
         S_IDLE: begin
            smp_ready   = ~coef_wr_req;
            coef_wr_ack = coef_wr_req;
            if (smp_valid && !coef_wr_req) begin
               in_cap    = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            dl_we     = 1'b1;
            k_nxt     = '0;
            state_nxt = S_MAC;
         end
         S_MAC: begin
            mac_en  = 1'b1;
            mac_clr = (k == '0);
            k_nxt   = k + TAP_W'(1);
            if (k == K_LAST) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            mac_en    = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            y_load     = 1'b1;
            wr_ptr_nxt = wr_ptr + TAP_W'(1);
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (!ena) begin
         smp_ready   = 1'b0;
         in_cap      = 1'b0;
         coef_wr_ack = 1'b0;
         dl_we       = 1'b0;
         mac_en      = 1'b0;
         mac_clr     = 1'b0;
         y_load      = 1'b0;
      end

      // Set has priority over clear so a simultaneous overrun is never lost.
      if (smp_valid && !smp_ready) ovr_nxt = 1'b1;
      else if (ovr_clr)            ovr_nxt = 1'b0;
      else                         ovr_nxt = ovr;
   end

   // Outside a granted write the shared RAM port follows the tap counter.
   assign coef_we   = coef_wr_ack;
   assign coef_addr = coef_wr_ack ? coef_wr_addr : k;
   assign dl_waddr  = wr_ptr;
   assign dl_raddr  = wr_ptr - k;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a small behavioural FIR datapath
// (delay line, coefficient RAM, one-stage product pipe, accumulator) driven
// by the controller's addresses and strobes.
module tb_fir_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       smp_valid;
   logic       smp_ready;
   logic       in_cap;
   logic       dl_we;
   logic [2:0] dl_waddr;
   logic [2:0] dl_raddr;
   logic       coef_wr_req;
   logic [2:0] coef_wr_addr;
   logic       coef_wr_ack;
   logic [2:0] coef_addr;
   logic       coef_we;
   logic       mac_clr;
   logic       mac_en;
   logic       y_load;
   logic       x_trio;
   logic       y_trio;
   logic       ovr;
   logic       ovr_clr;

   int ui;
   int coef_wdata;
   int in_reg;
   int dl_m [8];
   int coef_m [8];
   int p_m, acc_m, y_m;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int ra_seq [8];
   int acc_wait;

   fir_seq_ctrl #(.NTAPS(8), .TAP_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .smp_valid(smp_valid), .smp_ready(smp_ready), .in_cap(in_cap),
      .dl_we(dl_we), .dl_waddr(dl_waddr), .dl_raddr(dl_raddr),
      .coef_wr_req(coef_wr_req), .coef_wr_addr(coef_wr_addr),
      .coef_wr_ack(coef_wr_ack), .coef_addr(coef_addr), .coef_we(coef_we),
      .mac_clr(mac_clr), .mac_en(mac_en), .y_load(y_load),
      .x_trio(x_trio), .y_trio(y_trio), .ovr(ovr), .ovr_clr(ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural datapath, frozen by ena like the real one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            dl_m[i]   <= 0;
            coef_m[i] <= 0;
         end
         in_reg <= 0;
         p_m    <= 0;
         acc_m  <= 0;
         y_m    <= 0;
      end else if (ena) begin
         if (in_cap)  in_reg <= ui;
         if (dl_we)   dl_m[dl_waddr] <= in_reg;
         if (coef_we) coef_m[coef_addr] <= coef_wdata;
         p_m <= coef_m[coef_addr] * dl_m[dl_raddr];
         if (mac_en)  acc_m <= mac_clr ? 0 : acc_m + p_m;
         if (y_load)  y_m <= acc_m;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Raise smp_valid until in_cap, then drop it in the following (LOAD) cycle.
   task automatic accept(input int val);
      int n = 0;
      ui = val;
      smp_valid = 1'b1;
      #1;
      while (!in_cap && n < 30) begin
         tick();
         #1;
         n++;
      end
      chk("accept_seen", int'(in_cap), 1);
      acc_wait = n;
      tick();
      smp_valid = 1'b0;
   endtask

   // Full sample: timing masks relative to accept cycle T (bit i = T+i).
   task automatic do_sample(input int val, input int exp_y, input int exp_wa);
      int xm = 0, wm = 0, cm = 0, em = 0, lm = 0, tm = 0, wa = -1;
      accept(val);
      for (int i = 1; i <= 12; i++) begin
         if (i > 1) tick();
         #1;
         xm |= int'(x_trio)  << i;
         wm |= int'(dl_we)   << i;
         cm |= int'(mac_clr) << i;
         em |= int'(mac_en)  << i;
         lm |= int'(y_load)  << i;
         tm |= int'(y_trio)  << i;
         if (i == 1) wa = int'(dl_waddr);
         if (i >= 2 && i <= 9) ra_seq[i-2] = int'(dl_raddr);
      end
      chk("x_trio_mask",  xm, 32'h0002);
      chk("dl_we_mask",   wm, 32'h0002);
      chk("mac_clr_mask", cm, 32'h0004);
      chk("mac_en_mask",  em, 32'h07FC);
      chk("y_load_mask",  lm, 32'h0800);
      chk("y_trio_mask",  tm, 32'h1000);
      chk("dl_waddr",     wa, exp_wa);
      chk("y_value",      y_m, exp_y);
   endtask

   initial begin
      int exp_ra1 [8] = '{0, 7, 6, 5, 4, 3, 2, 1};
      int exp_ra9 [3] = '{0, 7, 6};
      int first_ack;
      int lm;

      rst_n = 1'b0; ena = 1'b1; smp_valid = 1'b0; coef_wr_req = 1'b0;
      coef_wr_addr = 3'd0; ovr_clr = 1'b0; ui = 0; coef_wdata = 0;
      #1;
      chk("rst_smp_ready", int'(smp_ready), 1);
      chk("rst_strobes", int'({in_cap, dl_we, coef_we, mac_en, mac_clr, y_load, x_trio, y_trio}), 0);
      chk("rst_addr", int'({dl_waddr, dl_raddr, coef_addr}), 0);
      chk("rst_ovr", int'(ovr), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Back-to-back coefficient writes 1..8.
      for (int a = 0; a < 7; a++) begin
         coef_wr_req = 1'b1; coef_wr_addr = 3'(a); coef_wdata = a + 1;
         #1;
         chk("coef_ack", int'(coef_wr_ack & coef_we), 1);
         chk("coef_addr_wr", int'(coef_addr), a);
         chk("coef_blocks_ready", int'(smp_ready), 0);
         tick();
      end
      // Last write collides with the first sample: write wins.
      coef_wr_addr = 3'd7; coef_wdata = 8; smp_valid = 1'b1; ui = 1;
      #1;
      chk("collide_ack", int'(coef_wr_ack), 1);
      chk("collide_ready", int'(smp_ready), 0);
      chk("collide_in_cap", int'(in_cap), 0);
      tick();
      coef_wr_req = 1'b0;
      chk("collide_ovr", int'(ovr), 1);

      // Impulse then zeros: outputs 1..8 then 0; wr_ptr wraps on sample 9.
      for (int n = 1; n <= 9; n++) begin
         do_sample((n == 1) ? 1 : 0, (n <= 8) ? n : 0, (n - 1) % 8);
         if (n == 1) begin
            chk("accept_next_cycle", acc_wait, 0);
            for (int j = 0; j < 8; j++) chk("raddr_s1", ra_seq[j], exp_ra1[j]);
            chk("wr_ptr_after1", int'(dl_waddr), 1);
         end
         if (n == 9)
            for (int j = 0; j < 3; j++) chk("raddr_s9", ra_seq[j], exp_ra9[j]);
      end
      chk("wr_ptr_after9", int'(dl_waddr), 1);

      chk("ovr_still_set", int'(ovr), 1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      #1;
      chk("ovr_cleared", int'(ovr), 0);

      // Coefficient request raised at MAC k=2 is granted in the first IDLE cycle.
      accept(0);
      tick(); tick(); tick();
      coef_wr_req = 1'b1; coef_wr_addr = 3'd2; coef_wdata = 3;
      #1;
      chk("busy_no_ack", int'(coef_wr_ack | coef_we), 0);
      chk("busy_coef_addr_k", int'(coef_addr), 2);
      first_ack = -1;
      for (int i = 5; i <= 30; i++) begin
         tick();
         #1;
         if (coef_wr_ack) begin
            first_ack = i;
            break;
         end
      end
      chk("late_ack_cycle", first_ack, 12);
      tick();
      coef_wr_req = 1'b0;

      // Overrun: sticky, cleared by ovr_clr, set wins over clear.
      accept(0);
      tick(); tick();
      smp_valid = 1'b1;
      #1;
      chk("ovr_pre", int'(ovr), 0);
      tick();
      smp_valid = 1'b0;
      #1;
      chk("ovr_set", int'(ovr), 1);
      tick(); tick(); tick();
      #1;
      chk("ovr_sticky", int'(ovr), 1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      #1;
      chk("ovr_clr", int'(ovr), 0);
      smp_valid = 1'b1; ovr_clr = 1'b1;
      tick();
      smp_valid = 1'b0; ovr_clr = 1'b0;
      #1;
      chk("ovr_set_wins", int'(ovr), 1);
      for (int i = 0; i < 30 && !smp_ready; i++) begin
         tick();
         #1;
      end
      chk("back_to_idle", int'(smp_ready), 1);

      // ena low for 5 cycles at MAC k=3: y_load moves from T+11 to T+16.
      accept(3);
      tick(); tick(); tick(); tick();
      ena = 1'b0;
      for (int f = 0; f < 5; f++) begin
         if (f > 0) tick();
         #1;
         chk("freeze_strobes", int'({in_cap, dl_we, coef_we, coef_wr_ack, mac_en, mac_clr, y_load, smp_ready}), 0);
         chk("freeze_k", int'(coef_addr), 3);
      end
      tick();
      ena = 1'b1;
      lm = 0;
      for (int i = 10; i <= 20; i++) begin
         if (i > 10) tick();
         #1;
         lm |= int'(y_load) << i;
      end
      chk("ena_y_load_shift", lm, 1 << 16);
      chk("ena_y_value", y_m, 3);

      // Asynchronous reset mid-MAC aborts the sample.
      accept(5);
      tick(); tick(); tick(); tick();
      #1;
      chk("pre_rst_waddr", int'(dl_waddr), 4);
      rst_n = 1'b0;
      #1;
      chk("midrst_waddr", int'(dl_waddr), 0);
      chk("midrst_addr", int'({dl_raddr, coef_addr}), 0);
      chk("midrst_strobes", int'({mac_en, mac_clr, dl_we, y_load, x_trio, y_trio}), 0);
      chk("midrst_ovr", int'(ovr), 0);
      chk("midrst_ready", int'(smp_ready), 1);
      tick(); tick();
      rst_n = 1'b1;
      lm = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         #1;
         lm |= int'(y_load) << i;
      end
      chk("abort_no_y_load", lm, 0);
      chk("post_rst_ready", int'(smp_ready), 1);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencing and arbitration controller for the time-multiplexed FIR datapath inside `tt_um_fir`. It accepts input samples, writes each one into the circular sample delay line and steps a single MAC across all taps. It arbitrates the shared coefficient-RAM port between host coefficient writes and MAC reads. Its sample-accept and result-valid strobes drive the `x_trio` and `y_trio` pins (`uio_out[6]` and `uio_out[7]`).

## Interface
Parameters:
- `NTAPS`, default 8: number of taps; power of two, range 2..16.
- `TAP_W`, default 3: `log2(NTAPS)`; width of all tap addresses and pointers.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global enable; low freezes all state.
- `smp_valid`  in  1  a new sample is present on `ui_in`.
- `smp_ready`  out  1  the controller can accept a sample this cycle.
- `in_cap`  out  1  `smp_valid & smp_ready`; the datapath input register captures `ui_in`.
- `dl_we`  out  1  delay-line write enable.
- `dl_waddr`  out  TAP_W  delay-line write address (= `wr_ptr`).
- `dl_raddr`  out  TAP_W  delay-line read address.
- `coef_wr_req`  in  1  host requests a coefficient write; held until acked.
- `coef_wr_addr`  in  TAP_W  coefficient index to write.
- `coef_wr_ack`  out  1  write granted; the RAM is written this cycle.
- `coef_addr`  out  TAP_W  shared coefficient-RAM address.
- `coef_we`  out  1  coefficient-RAM write enable (= `coef_wr_ack`).
- `mac_clr`  out  1  clear the accumulator, then load the first product.
- `mac_en`  out  1  accumulate the current product.
- `y_load`  out  1  the output register captures the accumulator.
- `x_trio`  out  1  sample-accepted pulse (registered `in_cap`).
- `y_trio`  out  1  result-valid pulse (= `y_load`, delayed one cycle).
- `ovr`  out  1  sticky overrun flag.
- `ovr_clr`  in  1  clears `ovr`.

## Operation
- FSM states: IDLE, LOAD, MAC, FLUSH, DONE.
- IDLE:
  - `smp_ready = ~coef_wr_req`.
  - `coef_wr_ack = coef_wr_req`; coefficient writes have priority over samples.
  - On `in_cap` the FSM goes to LOAD.
- LOAD: `dl_we=1`, `dl_waddr=wr_ptr`, tap counter `k` set to 0; next state MAC.
- MAC (NTAPS cycles):
  - `mac_en=1`, with `mac_clr=1` only when `k=0`.
  - `coef_addr=k`, `dl_raddr=(wr_ptr-k) mod NTAPS`.
  - `k` increments each cycle; after `k=NTAPS-1` the FSM goes to FLUSH.
- FLUSH: one cycle covering the datapath's one-stage product pipeline; `mac_en=1` so the last product is summed. `coef_addr` and `dl_raddr` are don't-care.
- DONE:
  - `y_load=1`.
  - `wr_ptr` increments modulo NTAPS, wrapping from NTAPS-1 to 0.
  - Next state IDLE.
- Coefficient requests outside IDLE are not acked; `coef_addr` stays `k` until IDLE. A request held from DONE is acked in the first IDLE cycle.
- `ovr`:
  - Set on any cycle with `smp_valid & ~smp_ready & ena`.
  - Cleared by `ovr_clr`; set wins when both occur in the same cycle.
- `ena=0`:
  - FSM, `k`, `wr_ptr`, `ovr`, `x_trio` and `y_trio` hold their values.
  - All single-cycle strobes are forced to 0: `in_cap`, `dl_we`, `coef_we`, `coef_wr_ack`, `mac_*`, `y_load`.
  - `smp_ready` is forced to 0.
- Reset (asynchronous, including mid-MAC):
  - State IDLE, `k=0`, `wr_ptr=0`, `ovr=0`.
  - All strobes, `x_trio` and `y_trio` are 0; addresses are 0.
  - `smp_ready` is 1 when `coef_wr_req=0`.
  - An aborted sample produces no `y_load`.

## Timing
- Accept in cycle T (`in_cap=1`). LOAD is at T+1, with `x_trio=1` for that cycle only.
- MAC runs T+2..T+1+NTAPS. FLUSH is at T+2+NTAPS. DONE (`y_load`) is at T+3+NTAPS; `y_trio=1` at T+4+NTAPS.
- IDLE is at T+4+NTAPS. Minimum sample period is NTAPS+4 cycles: 12 for NTAPS=8.
- `coef_wr_ack` is combinational with `coef_wr_req` in IDLE; one write per cycle; back-to-back writes block samples.

## Test plan
- Reset, NTAPS=8, single `smp_valid` at T → `in_cap` at T; `x_trio` at T+1; `mac_clr` at T+2; `mac_en` high T+2..T+10; `y_load` at T+11; `y_trio` at T+12; `wr_ptr`=1 afterward.
- Coefficients {1,2,...,8}, impulse sample 1 followed by zeros → successive outputs 1,2,...,8 then 0. Check `dl_raddr` sequence 0,7,6,...,1 on the first sample.
- 9 samples → `wr_ptr` wraps 7→0 and `dl_waddr` of sample 9 = 0; `dl_raddr` for sample 9 starts 0,7,6.
- `coef_wr_req` and `smp_valid` together in IDLE → ack on the write and `smp_ready=0`. The sample is accepted the next cycle once the request drops. A request during MAC is acked first cycle of IDLE.
- `smp_valid` during MAC → `ovr`=1 and stays set; `ovr_clr` clears it; `ovr_clr` together with a new overrun → `ovr` stays 1.
- `ena=0` for 5 cycles mid-MAC → `k` frozen and no strobes; result timing shifts by exactly 5. `rst_n` low mid-MAC → IDLE, `wr_ptr`=0, no `y_load`.
